// File: rtl/mem_loader.sv
// mem_loader: framed byte-stream program loader in front of the 6502 memory.
// Frame format: 0xA5, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN payload bytes, CSUM.
// CSUM is the XOR of every byte after the sync byte. While a frame is in
// flight the CPU is held and the loader owns the write port. When the loader
// is idle the CPU bus passes straight through to memory.
module mem_loader #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    input  logic        CpuWE,
    input  logic [15:0] CpuAddress,
    input  logic [7:0]  CpuData,
    output logic        WE,
    output logic [15:0] Address,
    output logic [7:0]  DataIn,
    output logic        CpuHold,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_LO = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_LEN_LO  = 3'd3,
        ST_LEN_HI  = 3'd4,
        ST_DATA    = 3'd5,
        ST_CSUM    = 3'd6
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

    // Running checksum update: the checksum is a plain byte-wise XOR.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      state_r;
    logic        rx_ready_r;
    logic [15:0] ptr_r;
    logic [15:0] remain_r;      // LEN_LO is parked in the low byte until LEN_HI arrives
    logic [7:0]  xor_r;
    logic [31:0] tmo_cnt_r;
    logic        ld_we_r;
    logic [15:0] ld_addr_r;
    logic [7:0]  ld_data_r;
    logic        done_r;
    logic        error_r;

    logic        accept_s;
    logic [15:0] len_s;
    logic        tmo_hit_s;

    // Byte handshake, assembled length and timeout detection.
    always_comb begin
        accept_s  = RxValid && rx_ready_r;
        len_s     = {RxData, remain_r[7:0]};
        tmo_hit_s = 1'b0;
        if ((TMO_LIMIT != 32'd0) && (state_r != ST_IDLE) && !accept_s &&
            (tmo_cnt_r == (TMO_LIMIT - 32'd1))) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Frame-parsing FSM with registered memory-write and status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b0;
            ptr_r      <= 16'h0000;
            remain_r   <= 16'h0000;
            xor_r      <= 8'h00;
            tmo_cnt_r  <= 32'd0;
            ld_we_r    <= 1'b0;
            ld_addr_r  <= 16'h0000;
            ld_data_r  <= 8'h00;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            rx_ready_r <= 1'b1;
            done_r     <= 1'b0;
            ld_we_r    <= 1'b0;

            if ((state_r == ST_IDLE) || accept_s || tmo_hit_s) begin
                tmo_cnt_r <= 32'd0;
            end else if (TMO_LIMIT != 32'd0) begin
                tmo_cnt_r <= tmo_cnt_r + 32'd1;
            end else begin
                tmo_cnt_r <= 32'd0;
            end

            if (tmo_hit_s) begin
                state_r <= ST_IDLE;
                error_r <= 1'b1;
            end else if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (RxData == SYNC_BYTE) begin
                            state_r <= ST_ADDR_LO;
                            error_r <= 1'b0;
                            xor_r   <= 8'h00;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ADDR_LO: begin
                        ptr_r[7:0] <= RxData;
                        xor_r      <= csum_step(xor_r, RxData);
                        state_r    <= ST_ADDR_HI;
                    end
                    ST_ADDR_HI: begin
                        ptr_r[15:8] <= RxData;
                        xor_r       <= csum_step(xor_r, RxData);
                        state_r     <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        remain_r[7:0] <= RxData;
                        xor_r         <= csum_step(xor_r, RxData);
                        state_r       <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        remain_r[15:8] <= RxData;
                        xor_r          <= csum_step(xor_r, RxData);
                        if (len_s == 16'h0000) begin
                            state_r <= ST_CSUM;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        ld_we_r   <= 1'b1;
                        ld_addr_r <= ptr_r;
                        ld_data_r <= RxData;
                        ptr_r     <= ptr_r + 16'd1;
                        remain_r  <= remain_r - 16'd1;
                        xor_r     <= csum_step(xor_r, RxData);
                        if (remain_r == 16'd1) begin
                            state_r <= ST_CSUM;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_CSUM: begin
                        if (RxData == xor_r) begin
                            done_r <= 1'b1;
                        end else begin
                            error_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Memory bus ownership: CPU passthrough when idle, loader registers otherwise.
    always_comb begin
        Busy    = (state_r != ST_IDLE);
        CpuHold = Busy;
        RxReady = rx_ready_r;
        Done    = done_r;
        Error   = error_r;
        if (state_r == ST_IDLE) begin
            WE      = CpuWE;
            Address = CpuAddress;
            DataIn  = CpuData;
        end else begin
            WE      = ld_we_r;
            Address = ld_addr_r;
            DataIn  = ld_data_r;
        end
    end

endmodule
